// File: rtl/acc16_dmem_arb.sv
// acc16_dmem_arb: arbiter and sequencer for the acc16 single-port data memory.
// It shares the port between operand fetch (direct or indirect) and store writeback.
// An indirect fetch issues two back-to-back reads: pointer, then operand.
// Optional build macro ACC16_ARB_STATS_EN adds the conflict_cnt and stall_cnt counters.
module acc16_dmem_arb #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_req,
    input  logic          rd_ind,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall
`ifdef ACC16_ARB_STATS_EN
    ,
    output logic [15:0]   conflict_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StPtrWait,
        StDataWait
    } state_e;

    state_e        state_q, state_d;
    logic          last_wr_q, last_wr_d;  // 1 = last grant went to the write requester
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;

    // Next-state, arbitration and memory-port drive.
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        rd_ack    = 1'b0;
        wr_ack    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            StPtrWait: begin
                // Port reserved: follow the pointer just returned by memory.
                mem_en   = 1'b1;
                mem_addr = mem_rdata[AW-1:0];
                state_d  = StDataWait;
            end
            default: begin
                // StIdle and StDataWait: port is free, round-robin on conflict.
                state_d = StIdle;
                if (rd_req && (!wr_req || last_wr_q)) begin
                    rd_ack    = 1'b1;
                    mem_en    = 1'b1;
                    mem_addr  = rd_addr;
                    last_wr_d = 1'b0;
                    state_d   = rd_ind ? StPtrWait : StDataWait;
                end else if (wr_req) begin
                    wr_ack    = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                    last_wr_d = 1'b1;
                end
            end
        endcase

        // Nothing is accepted or issued while reset is applied.
        if (rst) begin
            rd_ack = 1'b0;
            wr_ack = 1'b0;
            mem_en = 1'b0;
            mem_we = 1'b0;
        end
    end

    // State register and registered fetch result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last_wr_q  <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_wr_q  <= last_wr_d;
            rd_valid_q <= (state_q == StDataWait);
            if (state_q == StDataWait) begin
                rd_data_q <= mem_rdata;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign stall    = rd_req & ~rd_ack;

`ifdef ACC16_ARB_STATS_EN
    logic port_free;
    assign port_free = (state_q != StPtrWait);

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (rd_req && wr_req && port_free && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_acc16_dmem_arb.sv
// tb_acc16_dmem_arb: self-checking bench for acc16_dmem_arb.
// Directed scenarios plus randomized traffic, checked against a transaction-level model.
// Honours ACC16_ARB_STATS_EN to also check the statistics counters.
module tb_acc16_dmem_arb;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 16;
    localparam int unsigned Words = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, rd_req, rd_ind, wr_req;
    logic [AW-1:0] rd_addr, wr_addr, mem_addr;
    logic [DW-1:0] wr_data, rd_data, mem_wdata, mem_rdata;
    logic          rd_ack, rd_valid, wr_ack, mem_en, mem_we, stall;
`ifdef ACC16_ARB_STATS_EN
    logic [15:0]   conflict_cnt, stall_cnt;
`endif

    acc16_dmem_arb #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .rd_ind      (rd_ind),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .stall       (stall)
`ifdef ACC16_ARB_STATS_EN
        ,
        .conflict_cnt(conflict_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // Environment: 1-cycle synchronous-read memory plus a backdoor fill port.
    logic          poke_en;
    logic [AW-1:0] poke_addr;
    logic [DW-1:0] poke_data;
    logic [DW-1:0] mem [Words];

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Reference model state (transaction level).
    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    int            cyc = 0;
    logic [DW-1:0] ref_mem [Words];
    bit            m_last_wr;      // last grant was the write side
    bit            m_ptr_pending;  // this cycle carries the operand read of an indirect fetch
    logic [AW-1:0] m_ptr_addr;
    int            due_q[$];       // cycle in which each accepted fetch must deliver
    logic [DW-1:0] val_q[$];       // value each accepted fetch must deliver
    int unsigned   m_conf, m_stall;
    bit            g_rd_prev, g_wr_prev;

    logic          obs_rd_ack, obs_wr_ack, obs_mem_we, obs_stall, obs_rd_valid;
    logic [AW-1:0] obs_mem_addr;
    logic [DW-1:0] obs_rd_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: compare DUT outputs against the model, then advance the model.
    task automatic step();
        bit            g_rd, g_wr, ptr_now, exp_en, exp_we, exp_valid;
        logic [AW-1:0] exp_addr, ptr;
        @(negedge clk);
        ptr_now  = m_ptr_pending;
        g_rd     = 1'b0;
        g_wr     = 1'b0;
        exp_en   = 1'b0;
        exp_we   = 1'b0;
        exp_addr = '0;
        if (!rst) begin
            if (ptr_now) begin
                exp_en   = 1'b1;
                exp_addr = m_ptr_addr;
            end else begin
                if (rd_req && wr_req) begin
                    g_rd = m_last_wr;
                    g_wr = !m_last_wr;
                end else begin
                    g_rd = rd_req;
                    g_wr = wr_req;
                end
                if (g_rd) begin
                    exp_en   = 1'b1;
                    exp_addr = rd_addr;
                end
                if (g_wr) begin
                    exp_en   = 1'b1;
                    exp_we   = 1'b1;
                    exp_addr = wr_addr;
                end
            end
        end

        check_eq("rd_ack", 32'(rd_ack), 32'(g_rd));
        check_eq("wr_ack", 32'(wr_ack), 32'(g_wr));
        check_eq("mem_en", 32'(mem_en), 32'(exp_en));
        check_eq("mem_we", 32'(mem_we), 32'(exp_we));
        check_eq("stall", 32'(stall), 32'(rd_req && !g_rd));
        if (exp_en) check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_we) check_eq("mem_wdata", 32'(mem_wdata), 32'(wr_data));

        exp_valid = (due_q.size() != 0) && (due_q[0] == cyc);
        check_eq("rd_valid", 32'(rd_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("rd_data", 32'(rd_data), 32'(val_q[0]));
            void'(due_q.pop_front());
            void'(val_q.pop_front());
        end

        obs_rd_ack   = rd_ack;
        obs_wr_ack   = wr_ack;
        obs_mem_we   = mem_we;
        obs_mem_addr = mem_addr;
        obs_stall    = stall;
        obs_rd_valid = rd_valid;
        obs_rd_data  = rd_data;

        if (rst) begin
            m_ptr_pending = 1'b0;
            m_last_wr     = 1'b1;
            m_conf        = 0;
            m_stall       = 0;
            due_q.delete();
            val_q.delete();
        end else begin
            if (rd_req && wr_req && !ptr_now && m_conf < 65535) m_conf++;
            if (rd_req && !g_rd && m_stall < 65535) m_stall++;
            m_ptr_pending = 1'b0;
            if (g_wr) begin
                ref_mem[wr_addr] = wr_data;
                m_last_wr = 1'b1;
            end
            if (g_rd) begin
                m_last_wr = 1'b0;
                if (rd_ind) begin
                    ptr           = ref_mem[rd_addr][AW-1:0];
                    m_ptr_pending = 1'b1;
                    m_ptr_addr    = ptr;
                    due_q.push_back(cyc + 3);
                    val_q.push_back(ref_mem[ptr]);
                end else begin
                    due_q.push_back(cyc + 2);
                    val_q.push_back(ref_mem[rd_addr]);
                end
            end
        end
        g_rd_prev = g_rd;
        g_wr_prev = g_wr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        ref_mem[a] = d;
        step();
        poke_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b0; rd_ind = 1'b0; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        m_last_wr = 1'b1; m_ptr_pending = 1'b0; m_ptr_addr = '0;
        m_conf = 0; m_stall = 0; g_rd_prev = 1'b0; g_wr_prev = 1'b0;
        @(posedge clk);
        #1;
        // Fill memory under reset.
        for (int i = 0; i < int'(Words); i++) begin
            poke_en    = 1'b1;
            poke_addr  = AW'(i);
            poke_data  = DW'($urandom);
            ref_mem[i] = poke_data;
            @(posedge clk);
            #1;
        end
        poke_en = 1'b0;

        // Reset state.
        step();
        check_eq("reset_rd_valid", 32'(obs_rd_valid), 32'h0);
        check_eq("reset_rd_data", 32'(obs_rd_data), 32'h0);
        rst = 1'b0;
        step();

        // Direct fetch.
        poke(AW'(5), 16'h1234);
        rd_req = 1'b1; rd_ind = 1'b0; rd_addr = AW'(5);
        step();
        check_eq("direct_ack", 32'(obs_rd_ack), 32'h1);
        check_eq("direct_addr", 32'(obs_mem_addr), 32'h5);
        check_eq("direct_stall", 32'(obs_stall), 32'h0);
        rd_req = 1'b0;
        step();
        check_eq("direct_t1_valid", 32'(obs_rd_valid), 32'h0);
        step();
        check_eq("direct_t2_valid", 32'(obs_rd_valid), 32'h1);
        check_eq("direct_t2_data", 32'(obs_rd_data), 32'h1234);

        // Indirect fetch.
        poke(AW'(7), 16'h0020);
        poke(AW'(32), 16'hBEEF);
        rd_req = 1'b1; rd_ind = 1'b1; rd_addr = AW'(7);
        step();
        check_eq("ind_addr0", 32'(obs_mem_addr), 32'h7);
        rd_req = 1'b0;
        step();
        check_eq("ind_addr1", 32'(obs_mem_addr), 32'h20);
        check_eq("ind_we1", 32'(obs_mem_we), 32'h0);
        step();
        check_eq("ind_t2_valid", 32'(obs_rd_valid), 32'h0);
        step();
        check_eq("ind_t3_valid", 32'(obs_rd_valid), 32'h1);
        check_eq("ind_t3_data", 32'(obs_rd_data), 32'hBEEF);

        // First conflict after reset goes to the fetch.
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_req = 1'b1; rd_ind = 1'b0; rd_addr = AW'(1);
        wr_req = 1'b1; wr_addr = AW'(2); wr_data = 16'h00AA;
        step();
        check_eq("conf_rd_ack", 32'(obs_rd_ack), 32'h1);
        check_eq("conf_wr_ack0", 32'(obs_wr_ack), 32'h0);
        check_eq("conf_stall", 32'(obs_stall), 32'h0);
        rd_req = 1'b0;
        step();
        check_eq("conf_wr_ack1", 32'(obs_wr_ack), 32'h1);
        check_eq("conf_we", 32'(obs_mem_we), 32'h1);
        check_eq("conf_addr", 32'(obs_mem_addr), 32'h2);
        wr_req = 1'b0;
        step();
        step();

        // Indirect fetch blocks a write during the pointer cycle.
        rd_req = 1'b1; rd_ind = 1'b1; rd_addr = AW'(7);
        step();
        rd_req = 1'b0;
        wr_req = 1'b1; wr_addr = AW'(32); wr_data = 16'h5555;
        step();
        check_eq("blk_wr_ack_ptr", 32'(obs_wr_ack), 32'h0);
        check_eq("blk_ptr_addr", 32'(obs_mem_addr), 32'h20);
        step();
        check_eq("blk_wr_ack_data", 32'(obs_wr_ack), 32'h1);
        wr_req = 1'b0;
        step();
        check_eq("blk_valid", 32'(obs_rd_valid), 32'h1);
        check_eq("blk_data", 32'(obs_rd_data), 32'hBEEF);

        // Reset during the pointer cycle drops the fetch.
        rd_req = 1'b1; rd_ind = 1'b1; rd_addr = AW'(7);
        step();
        rd_req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("rst_drop_valid", 32'(obs_rd_valid), 32'h0);
        end
        rd_req = 1'b1; rd_ind = 1'b0; rd_addr = AW'(5);
        step();
        check_eq("rst_next_ack", 32'(obs_rd_ack), 32'h1);
        rd_req = 1'b0;
        step();
        step();
        check_eq("rst_next_valid", 32'(obs_rd_valid), 32'h1);
        check_eq("rst_next_data", 32'(obs_rd_data), 32'h1234);

`ifdef ACC16_ARB_STATS_EN
        // Both requesters held for 10 cycles of direct reads.
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_req = 1'b1; rd_ind = 1'b0; rd_addr = AW'(3);
        wr_req = 1'b1; wr_addr = AW'(9); wr_data = 16'h0F0F;
        for (int i = 0; i < 10; i++) step();
        check_eq("stats_conflict", 32'(conflict_cnt), 32'd10);
        check_eq("stats_stall", 32'(stall_cnt), 32'd5);
        check_eq("stats_conflict_model", 32'(conflict_cnt), 32'(m_conf));
        check_eq("stats_stall_model", 32'(stall_cnt), 32'(m_stall));
        rd_req = 1'b0;
        wr_req = 1'b0;
        repeat (3) step();
`endif

        // Randomized traffic; a request is held until the model says it was granted.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) begin
                rst = 1'b1;
                rd_req = 1'b0;
                wr_req = 1'b0;
            end else begin
                rst = 1'b0;
                if (!rd_req || g_rd_prev) begin
                    rd_req  = ($urandom_range(99) < 60);
                    rd_ind  = 1'($urandom_range(1));
                    rd_addr = AW'($urandom);
                end
                if (!wr_req || g_wr_prev) begin
                    wr_req  = ($urandom_range(99) < 50);
                    wr_addr = AW'($urandom);
                    wr_data = DW'($urandom);
                end
            end
            step();
        end
        rst = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;
        repeat (4) step();
        check_eq("drain_empty", 32'(due_q.size()), 32'h0);
`ifdef ACC16_ARB_STATS_EN
        check_eq("final_conflict", 32'(conflict_cnt), 32'(m_conf));
        check_eq("final_stall", 32'(stall_cnt), 32'(m_stall));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
